// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: sequencer for a batched dense layer, res[b][m] = sat(sum_n w[m][n]*x[b][n] >>> FRAC).
// Walks b (outer), m (middle), n (inner) and issues read addresses to external weight and input
// memories, whose data returns one cycle after the address. One result is written per N+2 cycles.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, abort        one-cycle run request / synchronous cancel of a run in progress
//   busy, done          run active / one-cycle completion pulse
//   w_addr, w_data      weight read address (m*N+n) and returned signed weight
//   x_addr, x_data      input read address (b*N+n) and returned signed input
//   res_we, res_addr,   result write strobe, address (b*M+m) and saturated signed data
//   res_data
//   sat_flag            sticky: some result of the current run saturated
module dense_seq_ctrl #(
    parameter int unsigned B     = 2,
    parameter int unsigned M     = 3,
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    localparam int unsigned WAW  = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int unsigned XAW  = (B * N > 1) ? $clog2(B * N) : 1,
    localparam int unsigned RAW  = (B * M > 1) ? $clog2(B * M) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WAW-1:0]   w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic [XAW-1:0]   x_addr,
    input  logic [WIDTH-1:0] x_data,
    output logic             res_we,
    output logic [RAW-1:0]   res_addr,
    output logic [WIDTH-1:0] res_data,
    output logic             sat_flag
);

    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    // Wide enough to sum N full-width products without overflow
    localparam int unsigned AW = 2 * WIDTH + $clog2(N) + 1;

    localparam logic signed [AW-1:0] MAX_V = AW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state, state_d;
    logic [BW-1:0]           b_cnt, b_d, b_nx;
    logic [MW-1:0]           m_cnt, m_d, m_nx;
    logic [NW-1:0]           n_cnt, n_d;
    logic signed [AW-1:0]    acc, acc_d, acc_sum, shifted;
    logic                    acc_en, acc_en_d;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]        sat_val;
    logic                    sat_hit;
    logic                    last_m, last_b;
    logic                    busy_d, done_d, res_we_d, sat_d;
    logic [WAW-1:0]          w_addr_d;
    logic [XAW-1:0]          x_addr_d;
    logic [RAW-1:0]          res_addr_d;
    logic [WIDTH-1:0]        res_data_d;

    // Datapath: product of the returned operands, running sum, floor shift and saturation
    always_comb begin
        prod    = $signed(w_data) * $signed(x_data);
        acc_sum = acc_en ? acc + AW'(prod) : acc;
        shifted = acc_sum >>> FRAC;
        sat_hit = 1'b0;
        sat_val = shifted[WIDTH-1:0];
        if (shifted > MAX_V) begin
            sat_hit = 1'b1;
            sat_val = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (shifted < MIN_V) begin
            sat_hit = 1'b1;
            sat_val = {1'b1, {(WIDTH - 1){1'b0}}};
        end
    end

    // Loop index advance: m wraps into b
    always_comb begin
        last_m = (m_cnt == MW'(M - 1));
        last_b = (b_cnt == BW'(B - 1));
        m_nx   = last_m ? '0 : m_cnt + MW'(1);
        b_nx   = last_m ? b_cnt + BW'(1) : b_cnt;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        b_d        = b_cnt;
        m_d        = m_cnt;
        n_d        = n_cnt;
        acc_d      = acc;
        acc_en_d   = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        w_addr_d   = w_addr;
        x_addr_d   = x_addr;
        res_we_d   = 1'b0;
        res_addr_d = res_addr;
        res_data_d = res_data;
        sat_d      = sat_flag;

        if (abort && (state == S_RUN || state == S_DRAIN || state == S_WRITE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        sat_d    = 1'b0;
                        b_d      = '0;
                        m_d      = '0;
                        n_d      = '0;
                        acc_d    = '0;
                        w_addr_d = '0;
                        x_addr_d = '0;
                    end
                end
                S_RUN: begin
                    // Data for this cycle's address arrives next cycle, so mark it for accumulation
                    acc_en_d = 1'b1;
                    acc_d    = acc_sum;
                    if (n_cnt == NW'(N - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        n_d      = n_cnt + NW'(1);
                        w_addr_d = w_addr + WAW'(1);
                        x_addr_d = x_addr + XAW'(1);
                    end
                end
                S_DRAIN: begin
                    // Last product folds in here; result is registered so res_we lines up with WRITE
                    state_d    = S_WRITE;
                    acc_d      = acc_sum;
                    res_we_d   = 1'b1;
                    res_addr_d = RAW'(b_cnt * M + m_cnt);
                    res_data_d = sat_val;
                    if (sat_hit) begin
                        sat_d = 1'b1;
                    end
                end
                S_WRITE: begin
                    acc_d = '0;
                    n_d   = '0;
                    if (last_m && last_b) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        m_d      = m_nx;
                        b_d      = b_nx;
                        w_addr_d = WAW'(m_nx * N);
                        x_addr_d = XAW'(b_nx * N);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            b_cnt    <= '0;
            m_cnt    <= '0;
            n_cnt    <= '0;
            acc      <= '0;
            acc_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_addr   <= '0;
            x_addr   <= '0;
            res_we   <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
            sat_flag <= 1'b0;
        end else begin
            state    <= state_d;
            b_cnt    <= b_d;
            m_cnt    <= m_d;
            n_cnt    <= n_d;
            acc      <= acc_d;
            acc_en   <= acc_en_d;
            busy     <= busy_d;
            done     <= done_d;
            w_addr   <= w_addr_d;
            x_addr   <= x_addr_d;
            res_we   <= res_we_d;
            res_addr <= res_addr_d;
            res_data <= res_data_d;
            sat_flag <= sat_d;
        end
    end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Testbench for dense_seq_ctrl (B=2, M=3, N=4, Q8.8): scoreboard of expected writes, negedge monitor.
module tb_dense_seq_ctrl;

    localparam int B = 2;
    localparam int M = 3;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, res_we, sat_flag;
    logic [3:0]  w_addr;
    logic [2:0]  x_addr, res_addr;
    logic [15:0] w_data, x_data, res_data;

    logic signed [15:0] wmem [M*N];
    logic signed [15:0] xmem [B*N];

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    dense_seq_ctrl #(.B(B), .M(M), .N(N), .WIDTH(16), .FRAC(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .x_addr   (x_addr),
        .x_data   (x_data),
        .res_we   (res_we),
        .res_addr (res_addr),
        .res_data (res_data),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address
    always @(posedge clk) begin
        w_data <= wmem[w_addr];
        x_data <= xmem[x_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops the oldest expected result
    always @(negedge clk) begin
        if (rst_n && res_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d expected=none",
                         res_addr, $signed(res_data));
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_addr", longint'(res_addr), longint'(mon_e.addr));
                chk("res_data", longint'($signed(res_data)), longint'(mon_e.data));
            end
        end
        if (rst_n && done) begin
            done_cnt++;
        end
    end

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < M * N; i++) wmem[i] = 16'(wv);
        for (int i = 0; i < B * N; i++) xmem[i] = 16'(xv);
    endtask

    task automatic push_exp(input int count, input int val);
        for (int k = 0; k < count; k++) exp_q.push_back('{addr: k, data: val});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start through one edge; returns at the sample point of cycle 1
    task automatic pulse_start(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic normal_run(input string tag, input int wv, input int xv, input int res,
                              input int exp_sat, input int s1, input int s2, input logic with_ab);
        int c;
        int last_we;
        int w0;
        int d0;
        fill(wv, xv);
        push_exp(B * M, res);
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start(with_ab);
        c = 1;
        last_we = 0;
        chk({tag, "_busy_c1"}, longint'(busy), 1);
        chk({tag, "_sat_c1"}, longint'(sat_flag), 0);
        while (!done && c < 200) begin
            start = (c == s1 || c == s2);
            step();
            c++;
            if (res_we) last_we = c;
            if (c == 5) chk({tag, "_sat_c5"}, longint'(sat_flag), 0);
            if (c == 7) chk({tag, "_sat_c7"}, longint'(sat_flag), longint'(exp_sat));
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, longint'(c), 37);
        chk({tag, "_last_we_cycle"}, longint'(last_we), 36);
        chk({tag, "_busy_at_done"}, longint'(busy), 0);
        chk({tag, "_sat_at_done"}, longint'(sat_flag), longint'(exp_sat));
        repeat (4) step();
        chk({tag, "_writes"}, longint'(wr_cnt - w0), 6);
        chk({tag, "_dones"}, longint'(done_cnt - d0), 1);
        chk({tag, "_queue_left"}, longint'(exp_q.size()), 0);
        chk({tag, "_sat_held"}, longint'(sat_flag), longint'(exp_sat));
    endtask

    initial begin
        int c;
        int w0;
        int d0;
        fill(0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_res_we", longint'(res_we), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk("rst_w_addr", longint'(w_addr), 0);
        chk("rst_x_addr", longint'(x_addr), 0);
        chk("rst_res_addr", longint'(res_addr), 0);
        chk("rst_res_data", longint'(res_data), 0);
        rst_n = 1'b1;
        step();

        // abort alone in IDLE does nothing
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", longint'(busy), 0);

        normal_run("ones", 256, 256, 1024, 0, 0, 0, 1'b0);
        normal_run("neg", -384, 128, -768, 0, 0, 0, 1'b0);
        normal_run("sat_pos", 32512, 32512, 32767, 1, 0, 0, 1'b0);
        normal_run("sat_neg", 32512, -32512, -32768, 1, 0, 0, 1'b0);
        normal_run("floor", -1, 1, -1, 0, 0, 0, 1'b0);
        normal_run("restart_ign", 256, 256, 1024, 0, 5, 36, 1'b0);

        // Reset during cycle 10: only the first result (cycle 6) escapes
        fill(256, 256);
        push_exp(1, 1024);
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start(1'b0);
        c = 1;
        while (c < 10) begin
            step();
            c++;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", longint'(busy), 0);
        chk("mrst_res_we", longint'(res_we), 0);
        chk("mrst_done", longint'(done), 0);
        chk("mrst_w_addr", longint'(w_addr), 0);
        chk("mrst_x_addr", longint'(x_addr), 0);
        chk("mrst_res_data", longint'(res_data), 0);
        chk("mrst_sat", longint'(sat_flag), 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (45) step();
        chk("mrst_writes", longint'(wr_cnt - w0), 1);
        chk("mrst_dones", longint'(done_cnt - d0), 0);
        chk("mrst_queue_left", longint'(exp_q.size()), 0);
        chk("mrst_busy_after", longint'(busy), 0);

        normal_run("after_rst", 256, 256, 1024, 0, 0, 0, 1'b0);

        // Abort during cycle 14: writes at cycles 6 and 12 only
        push_exp(2, 1024);
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start(1'b0);
        c = 1;
        while (c < 14) begin
            step();
            c++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_res_we", longint'(res_we), 0);
        repeat (40) step();
        chk("abort_writes", longint'(wr_cnt - w0), 2);
        chk("abort_dones", longint'(done_cnt - d0), 0);
        chk("abort_queue_left", longint'(exp_q.size()), 0);

        // start together with abort in IDLE: start wins
        normal_run("after_abort", 256, 256, 1024, 0, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
